// File: rtl/issue_select.sv
// ============================================================================
// issue_select : round-robin pick of up to N ready RS entries into issue latch
// Revision     : 1.0
// ============================================================================
`default_nettype none

module issue_select #(
  parameter int N            = 3,
  parameter int RS_SZ        = 32,
  parameter int MULT_LAT     = 4,
  parameter int B_MASK_WIDTH = 4,
  parameter int PAYLOAD_W    = 16
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic [RS_SZ*(PAYLOAD_W+B_MASK_WIDTH+3)-1:0]      rs_data,
  input  logic [RS_SZ-1:0]                                 rs_valid,
  input  logic [B_MASK_WIDTH-1:0]                          b_mm_resolve,
  input  logic                                             b_mm_mispred,
  output logic [RS_SZ-1:0]                                 rs_data_issuing,
  output logic [N*(PAYLOAD_W+B_MASK_WIDTH+3)-1:0]          issue_pkts,
  output logic [N-1:0]                                     issue_valid,
  output logic                                             mult_busy
);

  // Packet layout, LSB first: src1_ready, src2_ready, fu_type, b_mask, payload
  localparam int PKT_W   = PAYLOAD_W + B_MASK_WIDTH + 3;
  localparam int C_S1    = 0;
  localparam int C_S2    = 1;
  localparam int C_FU    = 2;
  localparam int C_BM_LO = 3;

  localparam int C_IDX_W = (RS_SZ > 1) ? $clog2(RS_SZ) : 1;
  localparam int C_SUM_W = C_IDX_W + 1;
  localparam int C_CNT_W = $clog2(N + 1);
  localparam int C_MC_W  = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

  localparam logic [C_SUM_W-1:0] C_RS_SZ  = C_SUM_W'(RS_SZ);
  localparam logic [C_IDX_W-1:0] C_LAST   = C_IDX_W'(RS_SZ - 1);
  localparam logic [C_CNT_W-1:0] C_N      = C_CNT_W'(N);
  localparam logic [C_MC_W-1:0]  C_MC_LD  = C_MC_W'(MULT_LAT - 1);

  logic [C_IDX_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [C_MC_W-1:0]          mult_cnt_q, mult_cnt_d;
  logic [N*PKT_W-1:0]         issue_pkts_q, issue_pkts_d;
  logic [N-1:0]               issue_valid_q, issue_valid_d;

  always_comb begin : comb_sel
    logic [C_SUM_W-1:0] sum;
    logic [C_IDX_W-1:0] idx;
    logic [C_IDX_W-1:0] last_idx;
    logic [PKT_W-1:0]   pkt;
    logic [C_CNT_W-1:0] picks;
    logic               squash;
    logic               mult_ok;
    logic               mult_pick;
    logic               any_pick;

    sum             = '0;
    idx             = '0;
    last_idx        = rr_ptr_q;
    pkt             = '0;
    picks           = '0;
    squash          = 1'b0;
    mult_ok         = 1'b0;
    mult_pick       = 1'b0;
    any_pick        = 1'b0;
    rs_data_issuing = '0;
    issue_pkts_d    = '0;
    issue_valid_d   = '0;

    // Circular scan starting at rr_ptr; the k-th eligible entry fills slot k
    for (int k = 0; k < RS_SZ; k++) begin
      sum     = {1'b0, rr_ptr_q} + C_SUM_W'(k);
      idx     = (sum >= C_RS_SZ) ? C_IDX_W'(sum - C_RS_SZ) : C_IDX_W'(sum);
      pkt     = rs_data[idx*PKT_W +: PKT_W];
      squash  = b_mm_mispred && (|(pkt[C_BM_LO +: B_MASK_WIDTH] & b_mm_resolve));
      mult_ok = !pkt[C_FU] || ((mult_cnt_q == '0) && !mult_pick);
      if (rs_valid[idx] && pkt[C_S1] && pkt[C_S2] && !squash && mult_ok && (picks < C_N)) begin
        rs_data_issuing[idx] = 1'b1;
        if (!b_mm_mispred)
          pkt[C_BM_LO +: B_MASK_WIDTH] = pkt[C_BM_LO +: B_MASK_WIDTH] & ~b_mm_resolve;
        for (int s = 0; s < N; s++) begin
          if (picks == C_CNT_W'(s)) begin
            issue_pkts_d[s*PKT_W +: PKT_W] = pkt;
            issue_valid_d[s]               = 1'b1;
          end
        end
        picks    = picks + C_CNT_W'(1);
        last_idx = idx;
        any_pick = 1'b1;
        if (pkt[C_FU])
          mult_pick = 1'b1;
      end
    end

    if (any_pick)
      rr_ptr_d = (last_idx == C_LAST) ? '0 : last_idx + C_IDX_W'(1);
    else
      rr_ptr_d = rr_ptr_q;

    // A squash never clears the counter: the multiplier is still occupied
    if (mult_pick)
      mult_cnt_d = C_MC_LD;
    else if (mult_cnt_q != '0)
      mult_cnt_d = mult_cnt_q - C_MC_W'(1);
    else
      mult_cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q      <= '0;
      mult_cnt_q    <= '0;
      issue_pkts_q  <= '0;
      issue_valid_q <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mult_cnt_q    <= mult_cnt_d;
      issue_pkts_q  <= issue_pkts_d;
      issue_valid_q <= issue_valid_d;
    end
  end

  assign issue_pkts  = issue_pkts_q;
  assign issue_valid = issue_valid_q;
  assign mult_busy   = (mult_cnt_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_issue_select.sv
// ============================================================================
// tb_issue_select : directed self-checking bench for issue_select
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_issue_select;

  localparam int N     = 3;
  localparam int RS_SZ = 32;
  localparam int BMW   = 4;
  localparam int PKT_W = 16 + BMW + 3;

  logic                     clock;
  logic                     reset;
  logic [RS_SZ*PKT_W-1:0]   rs_data;
  logic [RS_SZ-1:0]         rs_valid;
  logic [BMW-1:0]           b_mm_resolve;
  logic                     b_mm_mispred;
  logic [RS_SZ-1:0]         rs_data_issuing;
  logic [N*PKT_W-1:0]       issue_pkts;
  logic [N-1:0]             issue_valid;
  logic                     mult_busy;

  int n_cmp;
  int n_fail;

  issue_select #(
    .N(N), .RS_SZ(RS_SZ), .MULT_LAT(4), .B_MASK_WIDTH(BMW), .PAYLOAD_W(16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rs_data         (rs_data),
    .rs_valid        (rs_valid),
    .b_mm_resolve    (b_mm_resolve),
    .b_mm_mispred    (b_mm_mispred),
    .rs_data_issuing (rs_data_issuing),
    .issue_pkts      (issue_pkts),
    .issue_valid     (issue_valid),
    .mult_busy       (mult_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packet: {payload, b_mask, fu_type, src2_ready, src1_ready}
  function automatic logic [PKT_W-1:0] mk(input int idx, input logic fu, input logic [BMW-1:0] bm);
    return {16'(idx + 256), bm, fu, 1'b1, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_entry(input int idx, input logic fu, input logic [BMW-1:0] bm);
    rs_data[idx*PKT_W +: PKT_W] = mk(idx, fu, bm);
    rs_valid[idx]               = 1'b1;
  endtask

  task automatic clr_all();
    rs_data      = '0;
    rs_valid     = '0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < RS_SZ; i++) rs_data[i*PKT_W +: PKT_W] = PKT_W'($urandom);
    rs_valid     = $urandom;
    b_mm_resolve = BMW'($urandom);
    b_mm_mispred = 1'($urandom);
    repeat (3) tick();
    n_cmp++; if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b want 000", issue_valid); end
    n_cmp++; if (issue_pkts !== '0) begin n_fail++; $display("FAIL reset_pkts: got %h want 0", issue_pkts); end
    n_cmp++; if (mult_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", mult_busy); end
    clr_all();
    for (int i = 5; i <= 8; i++) set_entry(i, 1'b0, '0);
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_00E0) begin n_fail++; $display("FAIL reset_sel_from0: got %h want 000000e0", rs_data_issuing); end
    rs_valid = '0;
    #1 reset = 1'b1;
    tick();
    n_cmp++; if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL reset_release_valid: got %b want 000", issue_valid); end
  endtask

  task automatic test_round_robin();
    clr_all();
    for (int i = 0; i <= 5; i++) set_entry(i, 1'b0, '0);
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_0007) begin n_fail++; $display("FAIL rr_sel1: got %h want 00000007", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_valid !== 3'b111) begin n_fail++; $display("FAIL rr_valid1: got %b want 111", issue_valid); end
    n_cmp++; if (issue_pkts !== {mk(2,0,0), mk(1,0,0), mk(0,0,0)}) begin n_fail++; $display("FAIL rr_pkts1: got %h want %h", issue_pkts, {mk(2,0,0), mk(1,0,0), mk(0,0,0)}); end
    rs_valid[2:0] = 3'b000;
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_0038) begin n_fail++; $display("FAIL rr_sel2: got %h want 00000038", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {mk(5,0,0), mk(4,0,0), mk(3,0,0)}) begin n_fail++; $display("FAIL rr_pkts2: got %h want %h", issue_pkts, {mk(5,0,0), mk(4,0,0), mk(3,0,0)}); end
  endtask

  task automatic test_wrap();
    clr_all();
    set_entry(29, 1'b0, '0);
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h2000_0000) begin n_fail++; $display("FAIL wrap_sel29: got %h want 20000000", rs_data_issuing); end
    tick();
    clr_all();
    set_entry(31, 1'b0, '0); set_entry(0, 1'b0, '0); set_entry(2, 1'b0, '0); set_entry(5, 1'b0, '0);
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h8000_0005) begin n_fail++; $display("FAIL wrap_sel: got %h want 80000005", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {mk(2,0,0), mk(0,0,0), mk(31,0,0)}) begin n_fail++; $display("FAIL wrap_pkts: got %h want %h", issue_pkts, {mk(2,0,0), mk(0,0,0), mk(31,0,0)}); end
    clr_all();
    set_entry(2, 1'b0, '0); set_entry(3, 1'b0, '0);
    tick();
    n_cmp++; if (issue_pkts !== {{PKT_W{1'b0}}, mk(2,0,0), mk(3,0,0)}) begin n_fail++; $display("FAIL wrap_ptr3: got %h want %h", issue_pkts, {{PKT_W{1'b0}}, mk(2,0,0), mk(3,0,0)}); end
    n_cmp++; if (issue_valid !== 3'b011) begin n_fail++; $display("FAIL wrap_ptr3_valid: got %b want 011", issue_valid); end
  endtask

  task automatic test_empty();
    clr_all();
    #1;
    n_cmp++; if (rs_data_issuing !== '0) begin n_fail++; $display("FAIL empty_sel: got %h want 0", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL empty_valid: got %b want 000", issue_valid); end
    set_entry(2, 1'b0, '0); set_entry(3, 1'b0, '0);
    tick();
    n_cmp++; if (issue_pkts !== {{PKT_W{1'b0}}, mk(2,0,0), mk(3,0,0)}) begin n_fail++; $display("FAIL empty_ptr_held: got %h want %h", issue_pkts, {{PKT_W{1'b0}}, mk(2,0,0), mk(3,0,0)}); end
  endtask

  task automatic test_mult();
    clr_all();
    set_entry(4, 1'b1, '0); set_entry(7, 1'b1, '0); set_entry(9, 1'b0, '0);
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_0210) begin n_fail++; $display("FAIL mult_sel: got %h want 00000210", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {{PKT_W{1'b0}}, mk(9,0,0), mk(4,1,0)}) begin n_fail++; $display("FAIL mult_pkts: got %h want %h", issue_pkts, {{PKT_W{1'b0}}, mk(9,0,0), mk(4,1,0)}); end
    n_cmp++; if (issue_valid !== 3'b011) begin n_fail++; $display("FAIL mult_valid: got %b want 011", issue_valid); end
    rs_valid[4] = 1'b0;
    rs_valid[9] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      #1;
      n_cmp++; if (mult_busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_t%0d: got %b want 1", c, mult_busy); end
      n_cmp++; if (rs_data_issuing !== '0) begin n_fail++; $display("FAIL mult_block_t%0d: got %h want 0", c, rs_data_issuing); end
      tick();
    end
    n_cmp++; if (mult_busy !== 1'b0) begin n_fail++; $display("FAIL mult_free_t4: got %b want 0", mult_busy); end
    n_cmp++; if (rs_data_issuing !== 32'h0000_0080) begin n_fail++; $display("FAIL mult_sel_t4: got %h want 00000080", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {{2*PKT_W{1'b0}}, mk(7,1,0)}) begin n_fail++; $display("FAIL mult_pkts_t4: got %h want %h", issue_pkts, {{2*PKT_W{1'b0}}, mk(7,1,0)}); end
    n_cmp++; if (mult_busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_reload: got %b want 1", mult_busy); end
    clr_all();
    repeat (3) tick();
    n_cmp++; if (mult_busy !== 1'b0) begin n_fail++; $display("FAIL mult_drain: got %b want 0", mult_busy); end
  endtask

  task automatic test_mispredict();
    clr_all();
    set_entry(1, 1'b0, 4'd1); set_entry(2, 1'b0, 4'd2);
    b_mm_resolve = 4'd1;
    b_mm_mispred = 1'b1;
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_0004) begin n_fail++; $display("FAIL mispred_sel: got %h want 00000004", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {{2*PKT_W{1'b0}}, mk(2,0,4'd2)}) begin n_fail++; $display("FAIL mispred_pkts: got %h want %h", issue_pkts, {{2*PKT_W{1'b0}}, mk(2,0,4'd2)}); end
    n_cmp++; if (issue_valid !== 3'b001) begin n_fail++; $display("FAIL mispred_valid: got %b want 001", issue_valid); end
  endtask

  task automatic test_correct_resolve();
    clr_all();
    set_entry(3, 1'b0, 4'd3);
    b_mm_resolve = 4'd1;
    #1;
    n_cmp++; if (rs_data_issuing !== 32'h0000_0008) begin n_fail++; $display("FAIL resolve_sel: got %h want 00000008", rs_data_issuing); end
    tick();
    n_cmp++; if (issue_pkts !== {{2*PKT_W{1'b0}}, mk(3,0,4'd2)}) begin n_fail++; $display("FAIL resolve_bmask: got %h want %h", issue_pkts, {{2*PKT_W{1'b0}}, mk(3,0,4'd2)}); end
  endtask

  task automatic test_async_reset();
    clr_all();
    set_entry(10, 1'b1, '0); set_entry(11, 1'b0, '0);
    tick();
    n_cmp++; if (issue_valid !== 3'b011) begin n_fail++; $display("FAIL areset_pre_valid: got %b want 011", issue_valid); end
    n_cmp++; if (mult_busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre_busy: got %b want 1", mult_busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (issue_valid !== 3'b000) begin n_fail++; $display("FAIL areset_valid: got %b want 000", issue_valid); end
    n_cmp++; if (issue_pkts !== '0) begin n_fail++; $display("FAIL areset_pkts: got %h want 0", issue_pkts); end
    n_cmp++; if (mult_busy !== 1'b0) begin n_fail++; $display("FAIL areset_busy: got %b want 0", mult_busy); end
    clr_all();
    #1 reset = 1'b1;
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    clr_all();
    test_reset();
    test_round_robin();
    test_wrap();
    test_empty();
    test_mult();
    test_mispredict();
    test_correct_resolve();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
